// File: rtl/btn_pkg.sv
// Shared types for the push-button reader.
// Classification FSM state encodings and mode width.
package btn_pkg;

    localparam int MODE_W = 2;

    // 2'd3 is unreachable and is handled as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

endpackage

// File: rtl/button_reader_debounce_sync.sv
// Two-flop synchroniser plus debounce counter for a button pin.
// Ports: clk, rst (sync, active-high), btn_in (raw pin),
//   level (debounced, 1 = pressed), press_pulse/release_pulse
//   (registered strobes, first cycle of new level),
//   press_evt/release_evt (level changes on the coming edge).
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_evt,
    output logic release_evt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt;
    logic            pressed_raw;
    logic            change;

    assign pressed_raw = sync_q[1] ^ ACTIVE_LOW;

    // Level flips on the edge where the counter is at its last step.
    assign change      = (pressed_raw != level) && (db_cnt == DB_MAX);
    assign press_evt   = change & pressed_raw;
    assign release_evt = change & ~pressed_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle pin value so reset never looks like a press edge.
            sync_q        <= {2{ACTIVE_LOW}};
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], btn_in};
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            if (pressed_raw == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                level  <= pressed_raw;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_reader.sv
// Push-button reader: debounced level, press/release strobes,
// short/long press classification and a 2-bit mode index.
// Ports: clk, rst (sync, active-high), btn_in (raw pin),
//   btn_level, press_pulse, release_pulse, short_pulse,
//   long_pulse, mode[1:0] (+1 per short press, 0 on long).
module button_reader
    import btn_pkg::*;
#(
    parameter int CLK_HZ          = 48000000,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int LONG_CYCLES     = 48000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    output logic              btn_level,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              short_pulse,
    output logic              long_pulse,
    output logic [MODE_W-1:0] mode
);

    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES
        || CLK_HZ < 1) begin : g_bad_params
        $error("button_reader: illegal parameter set");
    end

    btn_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              press_evt;
    logic              release_evt;

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .level         (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_evt     (press_evt),
        .release_evt   (release_evt)
    );

    // FSM steps on the same edge as the level change, so short_pulse
    // lines up with release_pulse and long_pulse lands LONG_CYCLES
    // after press_pulse. Release is tested first so it wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            mode        <= '0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            case (state)
                ST_PRESSED: begin
                    if (release_evt) begin
                        state       <= ST_IDLE;
                        short_pulse <= 1'b1;
                        mode        <= mode + 1'b1;
                    end else if (hold_cnt == HOLD_MAX) begin
                        state      <= ST_HELD;
                        long_pulse <= 1'b1;
                        mode       <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (release_evt) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (press_evt) begin
                        state    <= ST_PRESSED;
                        hold_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with short debounce/long
// constants; expected values worked out by hand.
module tb_button_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic [1:0] mode;

    int n_chk  = 0;
    int n_pass = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_short = 0;
    int n_long  = 0;
    int n_both  = 0;
    int base;

    button_reader #(
        .CLK_HZ          (48000000),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse)   n_press++;
        if (release_pulse) n_rel++;
        if (short_pulse)   n_short++;
        if (long_pulse)    n_long++;
        if (press_pulse && release_pulse) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag, input int md);
        chk({tag, "_lvl"},   32'(btn_level),     0);
        chk({tag, "_press"}, 32'(press_pulse),   0);
        chk({tag, "_rel"},   32'(release_pulse), 0);
        chk({tag, "_short"}, 32'(short_pulse),   0);
        chk({tag, "_long"},  32'(long_pulse),    0);
        chk({tag, "_mode"},  32'(mode),          32'(md));
    endtask

    // Press for 8 ticks then release; returns on the release cycle.
    task automatic short_press(input int md);
        btn_in = 1'b0;
        tick(8);
        btn_in = 1'b1;
        tick(6);
        chk("sp_rel",   32'(release_pulse), 1);
        chk("sp_short", 32'(short_pulse),   1);
        chk("sp_mode",  32'(mode),          32'(md));
    endtask

    initial begin
        // Reset state
        tick(3);
        chk_idle("rst", 0);
        rst = 1'b0;
        // 3-cycle glitch is rejected
        btn_in = 1'b0;
        tick(3);
        btn_in = 1'b1;
        tick(10);
        chk("glitch_lvl", 32'(btn_level), 0);
        chk("glitch_cnt", 32'(n_press), 0);

        // Basic press / release latency
        btn_in = 1'b0;
        tick(5);
        chk("pr5_lvl",   32'(btn_level),   0);
        chk("pr5_press", 32'(press_pulse), 0);
        tick(1);
        chk("pr6_lvl",   32'(btn_level),   1);
        chk("pr6_press", 32'(press_pulse), 1);
        tick(1);
        chk("pr7_press", 32'(press_pulse), 0);
        tick(3);
        btn_in = 1'b1;
        tick(5);
        chk("rl5_rel", 32'(release_pulse), 0);
        chk("rl5_lvl", 32'(btn_level),     1);
        tick(1);
        chk("rl6_rel",   32'(release_pulse), 1);
        chk("rl6_short", 32'(short_pulse),   1);
        chk("rl6_long",  32'(long_pulse),    0);
        chk("rl6_mode",  32'(mode),          1);
        tick(1);
        chk("rl7_short", 32'(short_pulse), 0);
        chk("rl7_rel",   32'(release_pulse), 0);

        // Mode sequence from reset: 1,2,3,0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_idle("rst2", 0);
        short_press(1);
        short_press(2);
        short_press(3);
        short_press(0);

        // Long press from mode 2, held 40 cycles
        short_press(1);
        short_press(2);
        base = n_long;
        btn_in = 1'b0;
        tick(6);
        chk("lp_press", 32'(press_pulse), 1);
        tick(15);
        chk("lp15_long", 32'(long_pulse), 0);
        chk("lp15_mode", 32'(mode),       2);
        tick(1);
        chk("lp16_long", 32'(long_pulse), 1);
        chk("lp16_mode", 32'(mode),       0);
        tick(1);
        chk("lp17_long", 32'(long_pulse), 0);
        tick(17);
        chk("lp_once", 32'(n_long - base), 1);
        btn_in = 1'b1;
        tick(6);
        chk("lp_rel",   32'(release_pulse), 1);
        chk("lp_short", 32'(short_pulse),   0);
        chk("lp_mode",  32'(mode),          0);

        // Release event on the hold_cnt==15 edge: release wins
        base = n_long;
        btn_in = 1'b0;
        tick(6);
        chk("race_press", 32'(press_pulse), 1);
        tick(10);
        btn_in = 1'b1;
        tick(6);
        chk("race_rel",   32'(release_pulse), 1);
        chk("race_short", 32'(short_pulse),   1);
        chk("race_long",  32'(long_pulse),    0);
        chk("race_mode",  32'(mode),          1);
        tick(4);
        chk("race_nolong", 32'(n_long - base), 0);

        // Reset mid-press, button still held
        btn_in = 1'b0;
        tick(6);
        chk("mr_press", 32'(press_pulse), 1);
        tick(5);
        base = n_rel;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_idle("mr_rst", 0);
        tick(5);
        chk("mr5_press", 32'(press_pulse), 0);
        tick(1);
        chk("mr6_press", 32'(press_pulse), 1);
        chk("mr6_lvl",   32'(btn_level),   1);
        chk("mr_norel",  32'(n_rel - base), 0);
        btn_in = 1'b1;
        tick(10);

        chk("excl", 32'(n_both), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
